// File: rtl/up_counter_4bits_if.sv
// up_counter_4bits_if: count-enable, terminal flag and count value shared by the multiplier controller and its shift counter.
interface up_counter_4bits_if #(
    parameter int WIDTH = 4
);
    logic             CNT;
    logic             K;
    logic [WIDTH-1:0] Q;

    modport master (output CNT, input K, Q);
    modport slave  (input CNT, output K, Q);
endinterface

// File: rtl/up_counter_4bits.sv
// up_counter_4bits: enabled wrap-around up-counter whose all-ones flag marks the final shift of a multiply.
module up_counter_4bits #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    up_counter_4bits_if.slave bus
);
    // Zero at power-up so the counter is usable even if rst_n never pulses.
    logic [WIDTH-1:0] count_q = '0;
    logic [WIDTH-1:0] count_d;

    always_comb count_d = bus.CNT ? count_q + WIDTH'(1) : count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign bus.Q = count_q;
    assign bus.K = &count_q;
endmodule

// File: tb/tb_up_counter_4bits.sv
// tb_up_counter_4bits: directed vectors with literal expectations plus a per-cycle check against an arithmetic model.
module tb_up_counter_4bits;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_q = 0;

    up_counter_4bits_if #(.WIDTH(4)) bus ();

    up_counter_4bits #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model of the spec: reset wins, otherwise count modulo 16 when enabled.
    always @(posedge clk) model_q <= !rst_n ? 0 : (bus.CNT ? (model_q + 1) % 16 : model_q);

    always @(negedge clk) begin
        n_checks++;
        if (int'(bus.Q) != model_q) begin
            n_fail++;
            $display("FAIL model_q t=%0t: Q=%0d expected %0d", $time, bus.Q, model_q);
        end
        n_checks++;
        if (bus.K != (model_q == 15)) begin
            n_fail++;
            $display("FAIL model_k t=%0t: K=%0b expected %0b", $time, bus.K, model_q == 15);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.CNT = 1'b1;
        tick(2);
        chk("reset_q", int'(bus.Q), 0);
        chk("reset_k", int'(bus.K), 0);
        rst_n = 1'b1;
        bus.CNT = 1'b0;
        tick(1);
        chk("idle_q", int'(bus.Q), 0);

        bus.CNT = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            chk("full_q", int'(bus.Q), i % 16);
            chk("full_k", int'(bus.K), (i == 15) ? 1 : 0);
        end
        chk("full_end_q", int'(bus.Q), 0);

        tick(7);
        chk("hold_pre_q", int'(bus.Q), 7);
        bus.CNT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_q", int'(bus.Q), 7);
            chk("hold_k", int'(bus.K), 0);
        end
        bus.CNT = 1'b1;
        tick(1);
        chk("hold_step_q", int'(bus.Q), 8);

        tick(7);
        chk("term_q", int'(bus.Q), 15);
        chk("term_k", int'(bus.K), 1);
        bus.CNT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("term_hold_q", int'(bus.Q), 15);
            chk("term_hold_k", int'(bus.K), 1);
        end
        bus.CNT = 1'b1;
        tick(1);
        chk("wrap_q", int'(bus.Q), 0);
        chk("wrap_k", int'(bus.K), 0);

        tick(12);
        chk("prio_pre_q", int'(bus.Q), 12);
        rst_n = 1'b0;
        tick(1);
        chk("prio_q", int'(bus.Q), 0);
        chk("prio_k", int'(bus.K), 0);
        rst_n = 1'b1;
        tick(5);
        chk("pulse_pre_q", int'(bus.Q), 5);
        bus.CNT = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick(1);
        chk("pulse_q", int'(bus.Q), 5);

        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mul_start_q", int'(bus.Q), 0);
        for (int b = 0; b < 2; b++) begin
            bus.CNT = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                chk("mul_k", int'(bus.K), (i == 16) ? 1 : 0);
                tick(1);
            end
            chk("mul_end_q", int'(bus.Q), 0);
            chk("mul_end_k", int'(bus.K), 0);
            bus.CNT = 1'b0;
            tick(2);
            chk("mul_gap_q", int'(bus.Q), 0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
